// File: rtl/serial_addsub_engine.sv
// rtl/serial_addsub_engine.sv - digit-serial two's-complement adder/subtractor with start/done handshake
// Optional overflow flag built only when SERIAL_ADDSUB_OVF_EN is defined; otherwise ovf is tied to 0.
module serial_addsub_engine #(
   parameter int N = 8,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         sub,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   localparam int DIGITS = N / D;
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0] LAST_DIGIT = CW'(DIGITS - 1);

   generate
      if (N < 2 || D < 1 || D > N || (N % D) != 0) begin : g_param_check
         $error("serial_addsub_engine: N must be >= 2 and D must divide N");
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        state_q;
   state_t        state_d;
   logic [N-1:0]  a_sr;
   logic [N-1:0]  b_sr;
   logic [N-1:0]  acc_sr;
   logic          carry_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  sum_q;
   logic          cout_q;
   logic          done_q;

   logic [D-1:0]  a_dig;
   logic [D-1:0]  b_dig;
   logic [D:0]    dig_sum;
   logic [N-1:0]  acc_next;
   logic          accept;
   logic          step;
   logic          last;

   // D-bit ripple slice; the new digit enters the accumulator from the MSB side
   always_comb begin
      a_dig    = a_sr[D-1:0];
      b_dig    = b_sr[D-1:0];
      dig_sum  = {1'b0, a_dig} + {1'b0, b_dig} + {{D{1'b0}}, carry_q};
      acc_next = (acc_sr >> D) | (N'(dig_sum[D-1:0]) << (N - D));
   end

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      step    = 1'b0;
      last    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            last = (cnt_q == LAST_DIGIT);
            if (last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         a_sr    <= '0;
         b_sr    <= '0;
         acc_sr  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         done_q  <= step && last;
         if (accept) begin
            // subtract as a + ~b + 1: the +1 rides in on the initial carry
            a_sr    <= a;
            b_sr    <= sub ? ~b : b;
            carry_q <= sub;
            cnt_q   <= '0;
            acc_sr  <= '0;
         end else if (step) begin
            a_sr    <= a_sr >> D;
            b_sr    <= b_sr >> D;
            acc_sr  <= acc_next;
            carry_q <= dig_sum[D];
            cnt_q   <= cnt_q + CW'(1);
            if (last) begin
               sum_q  <= acc_next;
               cout_q <= dig_sum[D];
            end
         end
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   logic ovf_q;
   logic c_into_msb;

   // carry into the top bit recovered from the sum bit and its two addend bits
   always_comb begin
      c_into_msb = dig_sum[D-1] ^ a_dig[D-1] ^ b_dig[D-1];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         ovf_q <= 1'b0;
      end else if (step && last) begin
         ovf_q <= c_into_msb ^ dig_sum[D];
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign busy = (state_q == RUN);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule
